// File: rtl/dmac_reg_pkg.sv
// dmac_reg_pkg: register map, field positions, FSM states and AHB constants for the DMA register block
package dmac_reg_pkg;
    localparam logic [4:0]  OFF_SRC      = 5'h00;
    localparam logic [4:0]  OFF_DST      = 5'h04;
    localparam logic [4:0]  OFF_CTRL     = 5'h08;
    localparam logic [4:0]  OFF_STAT     = 5'h0C;
    localparam logic [10:0] OFF_INT_STAT = 11'h400;
    localparam logic [10:0] OFF_VERSION  = 11'h404;
    localparam int CTRL_INT_EN = 24;
    localparam int CTRL_START  = 31;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
endpackage

// File: rtl/dmac_ch_regs.sv
// dmac_ch_regs: one channel's SRC/DST/CTRL/done registers with busy gating and start pulse
module dmac_ch_regs #(
    parameter int LEN_W = 16
) (
    input  logic             hclk,
    input  logic             hrst,
    input  logic             wr_src,
    input  logic             wr_dst,
    input  logic             wr_ctrl,
    input  logic             wr_stat,
    input  logic [31:0]      wdata,
    input  logic             busy,
    input  logic             done_in,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             int_en,
    output logic             start,
    output logic             done
);
    import dmac_reg_pkg::*;

    // config writes are dropped while the engine runs; done is sticky with set priority over W1C
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            int_en <= 1'b0;
            start  <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_src && !busy) src <= wdata;
            if (wr_dst && !busy) dst <= wdata;
            if (wr_ctrl && !busy) begin
                len    <= wdata[LEN_W-1:0];
                int_en <= wdata[CTRL_INT_EN];
            end
            start <= wr_ctrl && !busy && wdata[CTRL_START];
            done  <= done_in || (done && !(wr_stat && wdata[STAT_DONE]));
        end
    end
endmodule

// File: rtl/dmac_ahb_regs.sv
// dmac_ahb_regs: AHB-Lite register slave for NUM_CH DMA channels; DMAC_REGS_ERR_RESP_EN enables ERROR responses
module dmac_ahb_regs #(
    parameter int          NUM_CH  = 4,
    parameter int          LEN_W   = 16,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                    hclk,
    input  logic                    hrst,
    input  logic                    s_hsel,
    input  logic [1:0]              s_htrans,
    input  logic                    s_hwrite,
    input  logic [31:0]             s_haddr,
    input  logic [2:0]              s_hsize,
    input  logic [3:0]              s_hprot,
    input  logic [31:0]             s_hwdata,
    output logic [31:0]             s_hrdata,
    output logic                    s_hready,
    output logic [1:0]              s_hresp,
    output logic [NUM_CH*32-1:0]    ch_src,
    output logic [NUM_CH*32-1:0]    ch_dst,
    output logic [NUM_CH*LEN_W-1:0] ch_len,
    output logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic [NUM_CH-1:0]       ch_done,
    output logic                    irq
);
    import dmac_reg_pkg::*;

    state_t            state, state_nx;
    logic [10:0]       d_addr;
    logic              d_write, d_legal;
    logic              accept, legal_a, wr_en;
    logic [31:0]       rdata;
    logic [31:0]       src_a [NUM_CH];
    logic [31:0]       dst_a [NUM_CH];
    logic [LEN_W-1:0]  len_a [NUM_CH];
    logic [NUM_CH-1:0] int_en, done, int_stat;
    logic              unused;

    assign unused  = ^{s_hprot, s_haddr[31:11], s_htrans[0]};
    assign accept  = s_hsel && s_htrans[1] && s_hready;
    assign legal_a = s_hsize == HSIZE_WORD && s_haddr[1:0] == 2'b00 &&
                     (s_haddr[10] ? s_haddr[9:3] == 7'd0
                                  : !s_haddr[4] && int'(s_haddr[9:5]) < NUM_CH);

    // state register and address-phase capture for the following data phase
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state   <= IDLE;
            d_addr  <= '0;
            d_write <= 1'b0;
            d_legal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                d_addr  <= s_haddr[10:0];
                d_write <= s_hwrite;
                d_legal <= legal_a;
            end
        end
    end

    // next state: illegal accesses either take the two-cycle ERROR path or complete silently in DATA
    always_comb begin
`ifdef DMAC_REGS_ERR_RESP_EN
        state_nx = state == ERR1 ? ERR2 : !accept ? IDLE : legal_a ? DATA : ERR1;
`else
        state_nx = accept ? DATA : IDLE;
`endif
    end

    assign s_hready = state != ERR1;
    assign s_hresp  = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign wr_en    = state == DATA && d_write && d_legal && !d_addr[10];
    assign int_stat = done & int_en;
    assign irq      = |int_stat;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && d_addr[9:5] == 5'(i);
        dmac_ch_regs #(.LEN_W(LEN_W)) u_ch (
            .hclk    (hclk),
            .hrst    (hrst),
            .wr_src  (sel && d_addr[4:0] == OFF_SRC),
            .wr_dst  (sel && d_addr[4:0] == OFF_DST),
            .wr_ctrl (sel && d_addr[4:0] == OFF_CTRL),
            .wr_stat (sel && d_addr[4:0] == OFF_STAT),
            .wdata   (s_hwdata),
            .busy    (ch_busy[i]),
            .done_in (ch_done[i]),
            .src     (src_a[i]),
            .dst     (dst_a[i]),
            .len     (len_a[i]),
            .int_en  (int_en[i]),
            .start   (ch_start[i]),
            .done    (done[i])
        );
        assign ch_src[i*32 +: 32]       = src_a[i];
        assign ch_dst[i*32 +: 32]       = dst_a[i];
        assign ch_len[i*LEN_W +: LEN_W] = len_a[i];
    end

    // read mux from the registered address; start bit and unused CTRL bits read 0
    always_comb begin
        rdata = '0;
        if (d_addr[10]) begin
            rdata = d_addr[10:0] == OFF_VERSION ? VERSION : 32'(int_stat);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (d_addr[9:5] == 5'(i)) begin
                    rdata = d_addr[4:0] == OFF_SRC  ? src_a[i] :
                            d_addr[4:0] == OFF_DST  ? dst_a[i] :
                            d_addr[4:0] == OFF_CTRL ? {7'd0, int_en[i], 24'(len_a[i])} :
                                                      {30'd0, done[i], ch_busy[i]};
                end
            end
        end
    end

    assign s_hrdata = (state == DATA && !d_write && d_legal) ? rdata : '0;
endmodule

// File: tb/tb_dmac_ahb_regs.sv
// tb_dmac_ahb_regs: directed self-checking bench for dmac_ahb_regs; ERROR checks follow DMAC_REGS_ERR_RESP_EN
module tb_dmac_ahb_regs;
    logic         hclk = 1'b0;
    logic         hrst = 1'b0;
    logic         s_hsel = 1'b0;
    logic [1:0]   s_htrans = 2'b00;
    logic         s_hwrite = 1'b0;
    logic [31:0]  s_haddr = '0;
    logic [2:0]   s_hsize = 3'b010;
    logic [3:0]   s_hprot = 4'b0011;
    logic [31:0]  s_hwdata = '0;
    logic [31:0]  s_hrdata;
    logic         s_hready;
    logic [1:0]   s_hresp;
    logic [127:0] ch_src, ch_dst;
    logic [63:0]  ch_len;
    logic [3:0]   ch_start;
    logic [3:0]   ch_busy = '0;
    logic [3:0]   ch_done = '0;
    logic         irq;
    int           checks = 0;
    int           passed = 0;
    logic [31:0]  r_data;
    logic         r_ready;
    logic [1:0]   r_resp;

    always #5 hclk = ~hclk;

    dmac_ahb_regs dut (
        .hclk(hclk), .hrst(hrst), .s_hsel(s_hsel), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_haddr(s_haddr), .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp), .ch_src(ch_src),
        .ch_dst(ch_dst), .ch_len(ch_len), .ch_start(ch_start), .ch_busy(ch_busy),
        .ch_done(ch_done), .irq(irq)
    );

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        s_hsel = 1'b1; s_htrans = 2'b10; s_hwrite = wr; s_haddr = a; s_hsize = sz;
    endtask

    task automatic bus_idle;
        s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        tick;
        addr_ph(wr, a, sz);
        tick;
        bus_idle;
        s_hwdata = d;
        @(negedge hclk);
        r_ready = s_hready; r_resp = s_hresp; r_data = s_hrdata;
    endtask

    task automatic test_reset;
        #1 hrst = 1'b1;
        tick; tick;
        hrst = 1'b0;
        tick;
        @(negedge hclk);
        checks++; if (s_hready !== 1'b1) $display("FAIL reset_hready got %b want 1", s_hready); else passed++;
        checks++; if (s_hresp !== 2'b00) $display("FAIL reset_hresp got %b want 00", s_hresp); else passed++;
        checks++; if (s_hrdata !== 32'h0) $display("FAIL reset_hrdata got %h want 0", s_hrdata); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
        checks++; if ({ch_src, ch_dst, ch_len, ch_start} !== '0) $display("FAIL reset_ch_outputs got nonzero want 0"); else passed++;
        tick;
        addr_ph(1'b1, 32'h000, 3'b010);
        tick;
        bus_idle;
        s_hwdata = 32'hDEAD_BEEF;
        #2 hrst = 1'b1;
        tick;
        hrst = 1'b0;
        tick;
        checks++; if (ch_src[31:0] !== 32'h0) $display("FAIL reset_abort_src got %h want 0", ch_src[31:0]); else passed++;
        checks++; if (s_hready !== 1'b1) $display("FAIL reset_abort_hready got %b want 1", s_hready); else passed++;
    endtask

    task automatic test_back_to_back;
        tick;
        addr_ph(1'b1, 32'h020, 3'b010);
        tick;
        s_hwdata = 32'h1000_0000;
        addr_ph(1'b0, 32'h020, 3'b010);
        tick;
        bus_idle;
        @(negedge hclk);
        checks++; if (s_hrdata !== 32'h1000_0000) $display("FAIL b2b_rdata got %h want 10000000", s_hrdata); else passed++;
        checks++; if (s_hready !== 1'b1) $display("FAIL b2b_hready got %b want 1", s_hready); else passed++;
        checks++; if (ch_src[63:32] !== 32'h1000_0000) $display("FAIL b2b_ch_src1 got %h want 10000000", ch_src[63:32]); else passed++;
    endtask

    task automatic test_ctrl_irq;
        xfer(1'b1, 32'h008, 32'h8100_0010, 3'b010);
        tick;
        checks++; if (ch_start !== 4'b0001) $display("FAIL ctrl_start_pulse got %b want 0001", ch_start); else passed++;
        checks++; if (ch_len[15:0] !== 16'h0010) $display("FAIL ctrl_len0 got %h want 0010", ch_len[15:0]); else passed++;
        tick;
        checks++; if (ch_start !== 4'b0000) $display("FAIL ctrl_start_once got %b want 0000", ch_start); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL irq_before_done got %b want 0", irq); else passed++;
        ch_done = 4'b0001;
        tick;
        ch_done = 4'b0000;
        checks++; if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq); else passed++;
        xfer(1'b0, 32'h008, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h0100_0010) $display("FAIL ctrl_readback got %h want 01000010", r_data); else passed++;
        xfer(1'b0, 32'h400, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h0000_0001) $display("FAIL int_stat got %h want 00000001", r_data); else passed++;
        xfer(1'b0, 32'h404, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h0002_0000) $display("FAIL version got %h want 00020000", r_data); else passed++;
        xfer(1'b1, 32'h00C, 32'h2, 3'b010);
        checks++; if (irq !== 1'b1) $display("FAIL irq_hold_in_w1c got %b want 1", irq); else passed++;
        tick;
        checks++; if (irq !== 1'b0) $display("FAIL irq_fall got %b want 0", irq); else passed++;
    endtask

    task automatic test_busy;
        ch_busy = 4'b0010;
        xfer(1'b1, 32'h024, 32'h1234, 3'b010);
        checks++; if ({r_ready, r_resp} !== 3'b100) $display("FAIL busy_resp got %b want 100", {r_ready, r_resp}); else passed++;
        tick;
        checks++; if (ch_dst[63:32] !== 32'h0) $display("FAIL busy_dst got %h want 0", ch_dst[63:32]); else passed++;
        xfer(1'b1, 32'h028, 32'h8000_0005, 3'b010);
        tick;
        checks++; if (ch_start !== 4'b0000) $display("FAIL busy_start got %b want 0000", ch_start); else passed++;
        checks++; if (ch_len[31:16] !== 16'h0) $display("FAIL busy_len got %h want 0000", ch_len[31:16]); else passed++;
        xfer(1'b0, 32'h02C, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h1) $display("FAIL busy_stat got %h want 00000001", r_data); else passed++;
        ch_busy = 4'b0000;
        xfer(1'b1, 32'h024, 32'h1234, 3'b010);
        tick;
        checks++; if (ch_dst[63:32] !== 32'h1234) $display("FAIL idle_dst got %h want 00001234", ch_dst[63:32]); else passed++;
    endtask

    task automatic test_done_race;
        ch_done = 4'b0100;
        tick;
        ch_done = 4'b0000;
        tick;
        addr_ph(1'b1, 32'h04C, 3'b010);
        tick;
        bus_idle;
        s_hwdata = 32'h2;
        ch_done = 4'b0100;
        tick;
        ch_done = 4'b0000;
        xfer(1'b0, 32'h04C, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h2) $display("FAIL race_done got %h want 00000002", r_data); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL race_irq_masked got %b want 0", irq); else passed++;
        xfer(1'b1, 32'h04C, 32'h2, 3'b010);
        xfer(1'b0, 32'h04C, 32'h0, 3'b010);
        checks++; if (r_data !== 32'h0) $display("FAIL w1c_done got %h want 0", r_data); else passed++;
    endtask

    task automatic test_illegal;
        xfer(1'b0, 32'h300, 32'h0, 3'b010);
`ifdef DMAC_REGS_ERR_RESP_EN
        checks++; if ({r_ready, r_resp} !== 3'b001) $display("FAIL err1_chidx got %b want 001", {r_ready, r_resp}); else passed++;
        @(posedge hclk);
        @(negedge hclk);
        checks++; if ({s_hready, s_hresp} !== 3'b101) $display("FAIL err2_chidx got %b want 101", {s_hready, s_hresp}); else passed++;
`else
        checks++; if ({r_ready, r_resp} !== 3'b100) $display("FAIL okay_chidx got %b want 100", {r_ready, r_resp}); else passed++;
        checks++; if (r_data !== 32'h0) $display("FAIL rdata_chidx got %h want 0", r_data); else passed++;
`endif
        xfer(1'b0, 32'h021, 32'h0, 3'b010);
`ifdef DMAC_REGS_ERR_RESP_EN
        checks++; if ({r_ready, r_resp} !== 3'b001) $display("FAIL err1_misalign got %b want 001", {r_ready, r_resp}); else passed++;
        tick;
`else
        checks++; if ({r_ready, r_resp, r_data} !== {3'b100, 32'h0}) $display("FAIL misalign got %h want 400000000", {r_ready, r_resp, r_data}); else passed++;
`endif
        xfer(1'b0, 32'h010, 32'h0, 3'b010);
`ifdef DMAC_REGS_ERR_RESP_EN
        checks++; if ({r_ready, r_resp} !== 3'b001) $display("FAIL err1_unmapped got %b want 001", {r_ready, r_resp}); else passed++;
        tick;
`else
        checks++; if ({r_ready, r_resp, r_data} !== {3'b100, 32'h0}) $display("FAIL unmapped got %h want 400000000", {r_ready, r_resp, r_data}); else passed++;
`endif
        xfer(1'b1, 32'h000, 32'hDEAD, 3'b000);
`ifdef DMAC_REGS_ERR_RESP_EN
        checks++; if ({r_ready, r_resp} !== 3'b001) $display("FAIL err1_size got %b want 001", {r_ready, r_resp}); else passed++;
        tick;
`else
        checks++; if ({r_ready, r_resp} !== 3'b100) $display("FAIL okay_size got %b want 100", {r_ready, r_resp}); else passed++;
`endif
        tick;
        checks++; if (ch_src[31:0] !== 32'h0) $display("FAIL size_discard got %h want 0", ch_src[31:0]); else passed++;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_ctrl_irq;
        test_busy;
        test_done_race;
        test_illegal;
        tick;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
